// File: rtl/cpu_dmem.sv
// -----------------------------------------------------------------------------
// cpu_dmem : data-memory stage placed directly after the core's execute stage.
//
// Contents:
//   * synchronous, byte-addressable word RAM with RV32 store lanes and
//     load sign/zero extension
//   * MMIO block at MMIO_BASE: GPIO_OUT (RW), GPIO_IN (RO, 2-flop synced),
//     TIMER (RW, free running), TIMER_CMP (RW, sticky compare interrupt)
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   ram_ctrl     [4:2] funct3, [1] write, [0] access enable
//   ram_addr     byte address of the access
//   ram_din      right-aligned store data
//   ram_dout     extended load data, one cycle after the request
//   misalign_err one-cycle pulse aligned with ram_dout for a rejected access
//   gpio_in      asynchronous external inputs
//   gpio_out     GPIO output register
//   timer_irq    sticky timer-compare interrupt
//
// Interface timing: there is no valid/ready handshake. A request is present
// in cycle N whenever ram_ctrl[0]=1 and is always accepted; its load result
// and error flag appear on ram_dout/misalign_err in cycle N+1 and only then.
// -----------------------------------------------------------------------------
module cpu_dmem #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h0001_0000,
  parameter int          GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            ram_ctrl,
  input  logic [31:0]           ram_addr,
  input  logic [31:0]           ram_din,
  output logic [31:0]           ram_dout,
  output logic                  misalign_err,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                  w_req;
  logic                  w_we;
  logic [2:0]            w_f3;
  logic                  w_is_ram;
  logic                  w_is_mmio;
  logic                  w_f3_ok;
  logic                  w_align_ok;
  logic                  w_err;
  logic                  w_rd;
  logic                  w_ram_wr;
  logic                  w_mmio_wr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_off;
  logic [1:0]            w_mmio_sel;

  assign w_req      = ram_ctrl[0];
  assign w_we       = ram_ctrl[1];
  assign w_f3       = ram_ctrl[4:2];
  assign w_is_ram   = (ram_addr[31:ADDR_WIDTH+2] == '0);
  assign w_is_mmio  = (ram_addr[31:4] == MMIO_BASE[31:4]);
  assign w_idx      = ram_addr[ADDR_WIDTH+1:2];
  assign w_off      = ram_addr[1:0];
  assign w_mmio_sel = ram_addr[3:2];

  // Stores only know SB/SH/SW; loads additionally have the unsigned forms.
  always_comb begin
    w_f3_ok = 1'b0;
    if (w_we) w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
    else      w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                        (w_f3 == 3'b100) || (w_f3 == 3'b101);
  end

  always_comb begin
    w_align_ok = 1'b0;
    case (w_f3[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = ~w_off[0];
      2'b10:   w_align_ok = (w_off == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
  end

  // Unmapped addresses never raise an error; they just read as zero.
  assign w_err     = w_req & (w_is_ram | w_is_mmio) &
                     (~w_f3_ok | ~w_align_ok | (w_is_mmio & (w_f3 != 3'b010)));
  assign w_rd      = w_req & ~w_we & ~w_err;
  assign w_ram_wr  = w_req &  w_we & ~w_err & w_is_ram;
  assign w_mmio_wr = w_req &  w_we & ~w_err & w_is_mmio;

  // ---------------------------------------------------------------------------
  // Store lane steering: data is replicated across lanes so each enabled lane
  // simply takes its own byte.
  // ---------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = ram_din;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{ram_din[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ram_din[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = ram_din;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = ram_din;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word RAM (contents are deliberately not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_ram_q;

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
    if (w_req & ~w_we & w_is_ram) r_ram_q <= r_mem[w_idx];
  end

  // ---------------------------------------------------------------------------
  // MMIO registers
  // ---------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] r_gpio_out;
  logic [GPIO_WIDTH-1:0] r_gpio_s1;
  logic [GPIO_WIDTH-1:0] r_gpio_s2;
  logic [31:0]           r_timer;
  logic [31:0]           r_timer_cmp;
  logic                  r_timer_irq;
  logic [31:0]           w_mmio_rdata;
  logic                  w_cmp_wr;

  assign w_cmp_wr = w_mmio_wr & (w_mmio_sel == 2'd3);

  // Read value reflects register state before this cycle's update.
  always_comb begin
    w_mmio_rdata = '0;
    case (w_mmio_sel)
      2'd0: w_mmio_rdata = 32'(r_gpio_out);
      2'd1: w_mmio_rdata = 32'(r_gpio_s2);
      2'd2: w_mmio_rdata = r_timer;
      2'd3: w_mmio_rdata = r_timer_cmp;
      default: w_mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out  <= '0;
      r_gpio_s1   <= '0;
      r_gpio_s2   <= '0;
      r_timer     <= '0;
      r_timer_cmp <= 32'hFFFF_FFFF;
      r_timer_irq <= 1'b0;
    end else begin
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;

      if (w_mmio_wr && (w_mmio_sel == 2'd0)) r_gpio_out <= ram_din[GPIO_WIDTH-1:0];

      // A software write to TIMER takes priority over the increment.
      if (w_mmio_wr && (w_mmio_sel == 2'd2)) r_timer <= ram_din;
      else                                   r_timer <= r_timer + 32'd1;

      if (w_cmp_wr) r_timer_cmp <= ram_din;

      // Writing TIMER_CMP acknowledges the interrupt, even on a fresh match.
      if (w_cmp_wr)                        r_timer_irq <= 1'b0;
      else if (r_timer == r_timer_cmp)     r_timer_irq <= 1'b1;
    end
  end

  assign gpio_out  = r_gpio_out;
  assign timer_irq = r_timer_irq;

  // ---------------------------------------------------------------------------
  // Response pipeline stage (cycle N -> N+1)
  // ---------------------------------------------------------------------------
  logic        r_rd_ram;
  logic        r_rd_mmio;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_err;
  logic [31:0] r_mmio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ram  <= 1'b0;
      r_rd_mmio <= 1'b0;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      r_err     <= 1'b0;
      r_mmio_q  <= '0;
    end else begin
      r_rd_ram  <= w_rd & w_is_ram;
      r_rd_mmio <= w_rd & w_is_mmio;
      r_f3      <= w_f3;
      r_off     <= w_off;
      r_err     <= w_err;
      r_mmio_q  <= (w_rd & w_is_mmio) ? w_mmio_rdata : 32'd0;
    end
  end

  assign misalign_err = r_err;

  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_word = r_rd_ram ? r_ram_q : r_mmio_q;

  always_comb begin
    w_byte = w_word[7:0];
    case (r_off)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    w_half = r_off[1] ? w_word[31:16] : w_word[15:0];
  end

  always_comb begin
    ram_dout = '0;
    if (r_rd_ram | r_rd_mmio) begin
      case (r_f3)
        3'b000:  ram_dout = {{24{w_byte[7]}}, w_byte};
        3'b001:  ram_dout = {{16{w_half[15]}}, w_half};
        3'b010:  ram_dout = w_word;
        3'b100:  ram_dout = {24'd0, w_byte};
        3'b101:  ram_dout = {16'd0, w_half};
        default: ram_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dmem.sv
// -----------------------------------------------------------------------------
// tb_cpu_dmem : self-checking bench for cpu_dmem.
// Reference model keeps memory as individual bytes and the MMIO/timer state
// as plain variables; each clock step predicts the N+1 response.
// -----------------------------------------------------------------------------
module tb_cpu_dmem;

  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          GW   = 8;

  logic          clk;
  logic          rst_n;
  logic [4:0]    ram_ctrl;
  logic [31:0]   ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic          misalign_err;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic          timer_irq;

  cpu_dmem #(.ADDR_WIDTH(AW), .MMIO_BASE(BASE), .GPIO_WIDTH(GW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_ctrl     (ram_ctrl),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .misalign_err (misalign_err),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [7:0]    m_mem [int unsigned];
  logic [31:0]   m_timer;
  logic [31:0]   m_cmp;
  logic          m_irq;
  logic [GW-1:0] m_gpio_out;
  logic [GW-1:0] m_s1;
  logic [GW-1:0] m_s2;
  logic [32:0]   exp_q[$];   // {misalign_err, ram_dout} for the next cycle

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  function automatic logic [4:0] ld(input logic [2:0] f3);
    return {f3, 1'b0, 1'b1};
  endfunction

  function automatic logic [4:0] st(input logic [2:0] f3);
    return {f3, 1'b1, 1'b1};
  endfunction

  task automatic model_reset();
    m_timer    = 32'd0;
    m_cmp      = 32'hFFFF_FFFF;
    m_irq      = 1'b0;
    m_gpio_out = '0;
    m_s1       = '0;
    m_s2       = '0;
    exp_q.delete();
    exp_q.push_back(33'd0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock step. Drives the request, checks last cycle's response
  // and the register outputs at the falling edge, then advances the model.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] din);
    logic        req, we, err, is_ram, is_mmio, legal;
    logic [2:0]  f3;
    int          nb;
    logic [31:0] rd, t, mask;
    logic [32:0] e;
    logic [31:0] n_timer, n_cmp;
    logic        n_irq;
    logic [GW-1:0] n_gpio;

    ram_ctrl = ctrl;
    ram_addr = addr;
    ram_din  = din;

    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: observed=empty required=entry");
      e = 33'd0;
    end else begin
      e = exp_q.pop_front();
    end
    check("ram_dout",     ram_dout, e[31:0]);
    check("misalign_err", {31'd0, misalign_err}, {31'd0, e[32]});
    check("gpio_out",     32'(gpio_out), 32'(m_gpio_out));
    check("timer_irq",    {31'd0, timer_irq}, {31'd0, m_irq});

    // Predict the response from pre-edge model state.
    req     = ctrl[0];
    we      = ctrl[1];
    f3      = ctrl[4:2];
    nb      = 1 << f3[1:0];
    is_ram  = (addr >> (AW + 2)) == 0;
    is_mmio = (addr >> 4) == (BASE >> 4);
    legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err     = req && (is_ram || is_mmio) &&
              (!legal || ((addr % nb) != 0) || (is_mmio && nb != 4));
    rd      = 32'd0;
    if (req && !we && !err) begin
      if (is_ram) begin
        for (int i = 0; i < nb; i++) rd = rd | (32'(m_mem[addr + i]) << (8 * i));
        if (!f3[2] && nb < 4) begin
          mask = (32'd1 << (8 * nb)) - 32'd1;
          if (rd[8 * nb - 1]) rd = rd | ~mask;
        end
      end else if (is_mmio) begin
        case (addr[3:2])
          2'd0: rd = 32'(m_gpio_out);
          2'd1: rd = 32'(m_s2);
          2'd2: rd = m_timer;
          default: rd = m_cmp;
        endcase
      end
    end
    exp_q.push_back({err, rd});

    // Advance model state across the coming edge.
    n_timer = m_timer + 32'd1;
    n_cmp   = m_cmp;
    n_irq   = m_irq || (m_timer == m_cmp);
    n_gpio  = m_gpio_out;
    if (req && we && !err) begin
      if (is_ram) begin
        for (int i = 0; i < nb; i++) begin
          t = din >> (8 * i);
          m_mem[addr + i] = t[7:0];
        end
      end else if (is_mmio) begin
        case (addr[3:2])
          2'd0: n_gpio = din[GW-1:0];
          2'd2: n_timer = din;
          2'd3: begin n_cmp = din; n_irq = 1'b0; end
          default: ;
        endcase
      end
    end
    m_s2       = m_s1;
    m_s1       = gpio_in;
    m_timer    = n_timer;
    m_cmp      = n_cmp;
    m_irq      = n_irq;
    m_gpio_out = n_gpio;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 32'd0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int op;
    logic [31:0] a;

    rst_n    = 1'b0;
    ram_ctrl = '0;
    ram_addr = '0;
    ram_din  = '0;
    gpio_in  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_dout", ram_dout, 32'd0);
    check("reset_err",  {31'd0, misalign_err}, 32'd0);
    check("reset_gpio", 32'(gpio_out), 32'd0);
    check("reset_irq",  {31'd0, timer_irq}, 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Timer reads 0 in the first cycle out of reset.
    step(ld(F_W), BASE + 32'h8, 0);
    // Word store / load: 0x8765_4321
    step(st(F_W), 32'h100, 32'h8765_4321);
    step(ld(F_W), 32'h100, 0);
    // Byte lane: 0xFFFF_FFA5, 0x0000_00A5, word 0x8765_A521
    step(st(F_B), 32'h101, 32'h0000_00A5);
    step(ld(F_B), 32'h101, 0);
    step(ld(F_BU), 32'h101, 0);
    step(ld(F_W), 32'h100, 0);
    // Half lane: 0xFFFF_8001, 0x0000_8001, misaligned LH, word 0x8001_A521
    step(st(F_H), 32'h102, 32'h0000_8001);
    step(ld(F_H), 32'h102, 0);
    step(ld(F_HU), 32'h102, 0);
    step(ld(F_H), 32'h103, 0);
    step(ld(F_W), 32'h100, 0);
    // Misaligned stores are dropped; bad funct3 flags an error.
    step(st(F_W), 32'h102, 32'hDEAD_BEEF);
    step(st(F_H), 32'h101, 32'hDEAD_BEEF);
    step(ld(3'b011), 32'h100, 0);
    step(ld(F_W), 32'h100, 0);
    // Unmapped: reads zero, writes ignored, no error.
    step(st(F_W), 32'h0002_0000, 32'h1234_5678);
    step(ld(F_W), 32'h0002_0000, 0);
    // GPIO
    step(st(F_W), BASE, 32'h0000_005A);
    gpio_in = 8'h3C;
    idle(3);
    step(ld(F_W), BASE + 32'h4, 0);
    step(st(F_B), BASE, 32'h0000_00FF);
    step(ld(F_W), BASE, 0);
    step(st(F_W), BASE + 32'h4, 32'hFFFF_FFFF);
    // Timer wrap and sticky compare interrupt.
    step(st(F_W), BASE + 32'h8, 32'hFFFF_FFFE);
    step(st(F_W), BASE + 32'hC, 32'h0000_0001);
    step(ld(F_W), BASE + 32'h8, 0);
    idle(6);
    step(ld(F_W), BASE + 32'hC, 0);
    step(st(F_W), BASE + 32'hC, 32'hFFFF_0000);
    idle(2);

    // Random traffic on a pre-initialised RAM window plus GPIO.
    for (int i = 0; i < 16; i++) step(st(F_W), 32'h200 + 32'(4 * i), $urandom);
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 15);
      a  = 32'h200 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) gpio_in = GW'($urandom);
      case (op)
        0, 1, 2, 3, 4: step(ld(3'($urandom_range(0, 2))), a, 0);
        5, 6:          step(ld(3'($urandom_range(4, 5))), a, 0);
        7:             step(ld(3'($urandom_range(0, 7))), a, 0);
        8, 9, 10, 11:  step(st(3'($urandom_range(0, 2))), a, $urandom);
        12:            step(ld(F_W), BASE + 32'h4, 0);
        13:            step(st(F_W), BASE, $urandom);
        14:            step(ld(F_W), BASE, 0);
        default:       step(5'd0, 32'd0, 32'd0);
      endcase
    end
    idle(1);

    // Reset during a pending load.
    ram_ctrl = ld(F_W);
    ram_addr = 32'h100;
    ram_din  = 32'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dout", ram_dout, 32'd0);
    check("midrst_err",  {31'd0, misalign_err}, 32'd0);
    check("midrst_gpio", 32'(gpio_out), 32'd0);
    check("midrst_irq",  {31'd0, timer_irq}, 32'd0);
    ram_ctrl = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst_hold_dout", ram_dout, 32'd0);
    rst_n = 1'b1;
    model_reset();
    step(ld(F_W), BASE + 32'h8, 0);   // timer restarted at 0
    step(ld(F_W), 32'h100, 0);        // RAM contents retained
    step(ld(F_W), BASE + 32'hC, 0);   // compare back to all-ones
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
